// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter datapath.
//   IIR_DIN_W / IIR_DOUT_W : sample widths into and out of the filter core
//   feed_state_e           : state encoding of the input feeder FSM
package iir_pkg;

  localparam int IIR_DIN_W  = 12;
  localparam int IIR_DOUT_W = 18;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } feed_state_e;

endpackage

// File: rtl/iir_sync_fifo.sv
// Synchronous FIFO, DEPTH x DW, with a registered read port.
//   clk, rst    : clock, asynchronous active-low reset
//   wr_en       : push wr_data (ignored while full)
//   rd_en       : pop head into rd_data (ignored while empty)
//   rd_data     : last popped word, held until the next pop, 0 after reset
//   full, empty : occupancy flags
//   fill        : occupancy, 0..DEPTH
module iir_sync_fifo #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   fill
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign fill  = cnt;

  // A push while full is dropped even if a pop frees a slot the same cycle.
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/iir_in_feeder.sv
// Input feeder for the multicycle IIR core. Buffers samples and releases
// exactly one per filter request as a one-cycle din_valid pulse.
//   clk, rst   : clock, asynchronous active-low reset
//   s_data/s_valid/s_ready : sample source interface (s_ready = not full)
//   iir_req    : next-sample request pulse from the filter (dout_prevalid)
//   din/din_valid : sample to filter; din held between pulses
//   fill       : FIFO occupancy 0..DEPTH
//   underrun   : sticky, a request was pending while the FIFO was empty
//   overflow   : sticky, a push or a request was dropped
//   clr_flags  : synchronous clear of the sticky flags (a set wins)
module iir_in_feeder
  import iir_pkg::*;
#(
  parameter int DW    = IIR_DIN_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          iir_req,
  output logic [DW-1:0] din,
  output logic          din_valid,
  output logic [AW:0]   fill,
  output logic          underrun,
  output logic          overflow,
  input  logic          clr_flags
);

  localparam logic [CW-1:0] CRED_MAX = {CW{1'b1}};

  feed_state_e   state, state_nxt;
  logic [CW-1:0] credit, credit_nxt;
  logic          full, empty;
  logic          pop, req_ok;
  logic          set_under, set_over;

  iir_sync_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (s_valid),
    .wr_data(s_data),
    .rd_en  (pop),
    .rd_data(din),
    .full   (full),
    .empty  (empty),
    .fill   (fill)
  );

  assign s_ready   = ~full;
  assign din_valid = (state == ISSUE);

  // Requests arriving at saturation are lost; they are reported as overflow.
  assign req_ok = iir_req && (credit != CRED_MAX);

  always_comb begin
    state_nxt = IDLE;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (credit != '0 && !empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    credit_nxt = credit;
    case ({req_ok, pop})
      2'b10:   credit_nxt = credit + 1'b1;
      2'b01:   credit_nxt = credit - 1'b1;
      default: credit_nxt = credit;
    endcase
  end

  assign set_under = (state == IDLE) && (credit != '0) && empty;
  assign set_over  = (s_valid && full) || (iir_req && credit == CRED_MAX);

  // Credit resets to 1: the core takes its first sample unrequested.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      credit <= CW'(1);
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (set_under)      underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
      if (set_over)       overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
    end
  end

endmodule
